// File: rtl/steer_quad_gen_pkg.sv
// steer_pkg: shared types and helpers for the steering quadrature generator.
//   step_t    : step request encoding passed from the step engine to quad_phase
//   fsm_t     : digital ramp FSM states
//   gray2     : 2-bit phase to quadrature {A,B} encoding
//   PEND_MAX  : saturation limit of the default-width spinner accumulator
package steer_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_CW   = 2'd1,
    STEP_CCW  = 2'd2
  } step_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } fsm_t;

  localparam int unsigned PEND_W_DEF = 8;
  localparam int          PEND_MAX   = (2 ** (PEND_W_DEF - 1)) - 1;

  // Symmetric saturation limit for a signed accumulator of width w.
  function automatic int pend_max(input int unsigned w);
    return (2 ** (w - 1)) - 1;
  endfunction

  // 0->00, 1->01, 2->11, 3->10
  function automatic logic [1:0] gray2(input logic [1:0] phase);
    return {phase[1], phase[1] ^ phase[0]};
  endfunction

endpackage

// File: rtl/steer_quad_gen_quad_phase.sv
// quad_phase: holds the quadrature phase and the registered outputs.
// Ports:
//   CLK, Reset_n  : clock, asynchronous active-low reset
//   step_valid    : qualifies step (one cycle per step-engine tick)
//   step          : requested step direction (STEP_NONE = no step)
//   steer         : registered gray-coded phase {A,B}
//   step_o        : one-cycle pulse per emitted step
//   dir_o         : direction of the last step (1 = clockwise), held
module quad_phase
  import steer_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       step_valid,
  input  step_t      step,
  output logic [1:0] steer,
  output logic       step_o,
  output logic       dir_o
);

  logic [1:0] phase_q;
  logic [1:0] phase_nxt;
  logic       do_step;

  assign do_step   = step_valid && (step != STEP_NONE);
  assign phase_nxt = (step == STEP_CW) ? phase_q + 2'd1 : phase_q - 2'd1;

  // Phase register and output stage; outputs update the cycle after the tick.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_q <= 2'd0;
      steer   <= 2'b00;
      step_o  <= 1'b0;
      dir_o   <= 1'b0;
    end else begin
      step_o <= 1'b0;
      if (do_step) begin
        phase_q <= phase_nxt;
        steer   <= gray2(phase_nxt);
        step_o  <= 1'b1;
        dir_o   <= (step == STEP_CW);
      end
    end
  end

endmodule

// File: rtl/steer_quad_gen.sv
// steer_quad_gen: turns left/right steering requests (and, optionally, spinner
// deltas) into the 2-bit quadrature pattern for the Sprint 2 core.
// Optional feature macro: STEER_SPIN_EN (spinner pending-step accumulator).
// Ports:
//   CLK, Reset_n : clock, asynchronous active-low reset
//   left, right  : digital steering levels (exactly one = request)
//   spin_delta   : signed relative motion, sampled when spin_strobe = 1
//   spin_strobe  : one-cycle qualifier for spin_delta
//   steer        : registered quadrature {A,B}
//   step_o       : one-cycle pulse per emitted step
//   dir_o        : direction of the last step (1 = clockwise)
module steer_quad_gen
  import steer_pkg::*;
#(
  parameter int unsigned CLKDIV      = 22500,
  parameter int unsigned PERIOD_SLOW = 8,
  parameter int unsigned PERIOD_FAST = 2,
  parameter int unsigned RAMP_STEPS  = 4,
  parameter int unsigned PEND_W      = 8
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       left,
  input  logic       right,
  input  logic [7:0] spin_delta,
  input  logic       spin_strobe,
  output logic [1:0] steer,
  output logic       step_o,
  output logic       dir_o
);

  localparam int unsigned PRE_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned CNT_W  = $clog2(PERIOD_SLOW + 1);
  // One spare value so ramp+1 never wraps, even for RAMP_STEPS = 1.
  localparam int unsigned RAMP_W = $clog2(RAMP_STEPS + 2);

  logic [PRE_W-1:0]  pre_q;
  logic              tick;
  logic              req_cw;
  logic              req_ccw;
  logic              req_any;

  fsm_t              state_q, state_d;
  logic [CNT_W-1:0]  rate_q, rate_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic [RAMP_W-1:0] ramp_inc;
  logic              held_cw_q, held_cw_d;

  step_t             dig_step;
  step_t             spin_step;
  step_t             step_sel;

  // Prescaler: one tick per CLKDIV cycles.
  assign tick = (pre_q == PRE_W'(CLKDIV - 1));

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  assign req_cw   = right & ~left;
  assign req_ccw  = left & ~right;
  assign req_any  = req_cw | req_ccw;
  assign ramp_inc = ramp_q + RAMP_W'(1);

  // Ramp FSM state register.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      rate_q    <= '0;
      period_q  <= CNT_W'(PERIOD_SLOW);
      ramp_q    <= '0;
      held_cw_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rate_q    <= rate_d;
      period_q  <= period_d;
      ramp_q    <= ramp_d;
      held_cw_q <= held_cw_d;
    end
  end

  // Ramp FSM next state; a reversal restarts the ramp and steps on the same tick.
  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    period_d  = period_q;
    ramp_d    = ramp_q;
    held_cw_d = held_cw_q;
    dig_step  = STEP_NONE;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            dig_step  = req_cw ? STEP_CW : STEP_CCW;
            state_d   = ST_HOLD;
            rate_d    = '0;
            ramp_d    = RAMP_W'(1);
            held_cw_d = req_cw;
          end
        end
        ST_HOLD: begin
          if (!req_any) begin
            state_d  = ST_IDLE;
            rate_d   = '0;
            ramp_d   = '0;
            period_d = CNT_W'(PERIOD_SLOW);
          end else if (req_cw != held_cw_q) begin
            dig_step  = req_cw ? STEP_CW : STEP_CCW;
            rate_d    = '0;
            ramp_d    = RAMP_W'(1);
            period_d  = CNT_W'(PERIOD_SLOW);
            held_cw_d = req_cw;
          end else if (rate_q == period_q - CNT_W'(1)) begin
            dig_step = held_cw_q ? STEP_CW : STEP_CCW;
            rate_d   = '0;
            if (ramp_inc >= RAMP_W'(RAMP_STEPS)) begin
              ramp_d = '0;
              if (period_q > CNT_W'(PERIOD_FAST)) begin
                period_d = period_q - CNT_W'(1);
              end
            end else begin
              ramp_d = ramp_inc;
            end
          end else begin
            rate_d = rate_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef STEER_SPIN_EN
  localparam int unsigned SUM_W  = ((PEND_W > 8) ? PEND_W : 8) + 2;
  localparam int          PLIM_I = pend_max(PEND_W);
  localparam logic signed [SUM_W-1:0] PLIM = SUM_W'(PLIM_I);
  localparam logic signed [SUM_W-1:0] NLIM = -SUM_W'(PLIM_I);

  logic signed [PEND_W-1:0] pend_q, pend_d;
  logic signed [SUM_W-1:0]  pend_ext;
  logic signed [SUM_W-1:0]  delta_ext;
  logic signed [SUM_W-1:0]  sum;
  logic                     spin_go;

  assign pend_ext  = {{(SUM_W - PEND_W){pend_q[PEND_W-1]}}, pend_q};
  assign delta_ext = {{(SUM_W - 8){spin_delta[7]}}, spin_delta};
  // Spinner steps only when the digital path is idle and not requesting.
  assign spin_go   = tick && (state_q == ST_IDLE) && !req_any && (pend_q != '0);

  // Accumulate strobed delta and drain one step toward zero, then saturate.
  always_comb begin
    sum       = pend_ext;
    spin_step = STEP_NONE;
    if (spin_strobe) begin
      sum = sum + delta_ext;
    end
    if (spin_go) begin
      if (pend_q[PEND_W-1]) begin
        sum       = sum + SUM_W'(1);
        spin_step = STEP_CCW;
      end else begin
        sum       = sum - SUM_W'(1);
        spin_step = STEP_CW;
      end
    end
    if (sum > PLIM) begin
      pend_d = PLIM[PEND_W-1:0];
    end else if (sum < NLIM) begin
      pend_d = NLIM[PEND_W-1:0];
    end else begin
      pend_d = sum[PEND_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  logic unused_spin;
  assign unused_spin = ^{spin_delta, spin_strobe, PEND_W[0]};
  assign spin_step   = STEP_NONE;
`endif

  // Digital request has priority over the spinner.
  assign step_sel = (dig_step != STEP_NONE) ? dig_step : spin_step;

  quad_phase u_quad_phase (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .step_valid (tick),
    .step       (step_sel),
    .steer      (steer),
    .step_o     (step_o),
    .dir_o      (dir_o)
  );

endmodule

// File: tb/tb_steer_quad_gen.sv
// Scoreboard bench for steer_quad_gen (CLKDIV=4, PERIOD_SLOW=4, PERIOD_FAST=2,
// RAMP_STEPS=2). Expected steps carry the cycle (posedges since reset release)
// at which step_o is observed, the steer value and dir_o.
module tb_steer_quad_gen;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic [7:0] spin_delta = 8'd0;
  logic       spin_strobe = 1'b0;
  logic [1:0] steer;
  logic       step_o;
  logic       dir_o;

  typedef struct {
    int         cyc;
    logic [1:0] steer;
    logic       dir;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc;
  int         n_total = 0;
  int         n_pass  = 0;
  logic [1:0] gtab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always #5 CLK = ~CLK;

  steer_quad_gen #(
    .CLKDIV      (4),
    .PERIOD_SLOW (4),
    .PERIOD_FAST (2),
    .RAMP_STEPS  (2),
    .PEND_W      (8)
  ) dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .left        (left),
    .right       (right),
    .spin_delta  (spin_delta),
    .spin_strobe (spin_strobe),
    .steer       (steer),
    .step_o      (step_o),
    .dir_o       (dir_o)
  );

  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic ok, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic push(input int c, input logic [1:0] s, input logic d);
    exp_t e;
    e.cyc = c; e.steer = s; e.dir = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 3000) begin
      @(negedge CLK);
      guard++;
    end
    check("wait_bound", cyc >= n, cyc, n);
  endtask

  // Assert reset, check the asynchronous reset state, then release.
  task automatic start_test(input logic l, input logic r);
    @(negedge CLK);
    Reset_n = 1'b0; left = l; right = r; spin_strobe = 1'b0; spin_delta = 8'd0;
    exp_q.delete();
    #1;
    check("reset_steer", steer == 2'b00, int'(steer), 0);
    check("reset_step",  step_o == 1'b0, int'(step_o), 0);
    check("reset_dir",   dir_o == 1'b0, int'(dir_o), 0);
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  task automatic end_test();
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  task automatic strobe(input logic [7:0] d);
    spin_delta = d; spin_strobe = 1'b1;
    @(negedge CLK);
    spin_strobe = 1'b0;
  endtask

  // Monitor: every step_o pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    exp_t e;
    if (Reset_n && step_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step", 1'b0, cyc, -1);
      end else begin
        e = exp_q.pop_front();
        check("step_cycle", cyc == e.cyc, cyc, e.cyc);
        check("step_steer", steer == e.steer, int'(steer), int'(e.steer));
        check("step_dir",   dir_o == e.dir, int'(dir_o), int'(e.dir));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: idle after reset
    start_test(1'b0, 1'b0);
    wait_cyc(100);
    check("idle_steer", steer == 2'b00, int'(steer), 0);
    check("idle_dir",   dir_o == 1'b0, int'(dir_o), 0);
    end_test();

    // 2: right held, ramp 4 -> 3 -> 2 then stays at 2
    start_test(1'b0, 1'b1);
    push(4, 2'b01, 1'b1);  push(20, 2'b11, 1'b1); push(32, 2'b10, 1'b1);
    push(44, 2'b00, 1'b1); push(52, 2'b01, 1'b1); push(60, 2'b11, 1'b1);
    push(68, 2'b10, 1'b1); push(76, 2'b00, 1'b1);
    wait_cyc(78);
    right = 1'b0;
    wait_cyc(100);
    check("hold_dir_cw", dir_o == 1'b1, int'(dir_o), 1);
    end_test();

    // 3: left held, then both (no request), then right alone at slow period
    start_test(1'b1, 1'b0);
    push(4, 2'b10, 1'b0);  push(20, 2'b11, 1'b0); push(32, 2'b01, 1'b0);
    push(44, 2'b00, 1'b0); push(64, 2'b01, 1'b1); push(80, 2'b11, 1'b1);
    wait_cyc(46);
    right = 1'b1;
    wait_cyc(62);
    left = 1'b0;
    wait_cyc(82);
    right = 1'b0;
    wait_cyc(100);
    end_test();

    // 4: right for 10 ticks, reversal steps CCW on the same tick, ramp restarts
    start_test(1'b0, 1'b1);
    push(4, 2'b01, 1'b1);  push(20, 2'b11, 1'b1); push(32, 2'b10, 1'b1);
    push(44, 2'b11, 1'b0); push(60, 2'b01, 1'b0); push(72, 2'b00, 1'b0);
    wait_cyc(42);
    right = 1'b0; left = 1'b1;
    wait_cyc(74);
    left = 1'b0;
    wait_cyc(90);
    check("rev_dir_ccw", dir_o == 1'b0, int'(dir_o), 0);
    end_test();

    // 5: spinner path
    start_test(1'b0, 1'b0);
`ifdef STEER_SPIN_EN
    push(4, 2'b01, 1'b1); push(8, 2'b11, 1'b1); push(12, 2'b10, 1'b1);
    for (int j = 0; j < 127; j++) push(24 + 4 * j, gtab[j % 4], 1'b1);
    push(544, 2'b01, 1'b0); push(548, 2'b00, 1'b0); push(552, 2'b10, 1'b0);
    wait_cyc(1);
    strobe(8'd3);
    wait_cyc(20);
    spin_delta = 8'd100; spin_strobe = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    spin_strobe = 1'b0;
    wait_cyc(540);
    spin_delta = 8'd2; spin_strobe = 1'b1;
    @(negedge CLK);
    spin_delta = 8'hFB;
    @(negedge CLK);
    spin_strobe = 1'b0;
    wait_cyc(570);
`else
    wait_cyc(1);
    strobe(8'd3);
    wait_cyc(40);
`endif
    end_test();

    // 6: asynchronous reset mid-hold at period 2, then fresh ramp
    start_test(1'b0, 1'b1);
    push(4, 2'b01, 1'b1);  push(20, 2'b11, 1'b1); push(32, 2'b10, 1'b1);
    push(44, 2'b00, 1'b1); push(52, 2'b01, 1'b1);
    wait_cyc(54);
    Reset_n = 1'b0;
    #1;
    check("async_rst_steer", steer == 2'b00, int'(steer), 0);
    check("async_rst_dir",   dir_o == 1'b0, int'(dir_o), 0);
    end_test();
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    push(4, 2'b01, 1'b1); push(20, 2'b11, 1'b1);
    wait_cyc(26);
    right = 1'b0;
    wait_cyc(40);
    end_test();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
